cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/rr_picker.sv | 34 +++
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 tb/tb_cdb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter and its helpers.
package cdb_arbiter_pkg;

  localparam int N_REQ      = 3;
  localparam int ROB_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Requester positions on the request vector
  localparam int REQ_ALU = 0;
  localparam int REQ_LSB = 1;
  localparam int REQ_BRU = 2;

  // Round-robin pointer value that follows a grant to slot idx
  function automatic int nextPtr(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the
// pointer (wrapping) wins. Kept generic so issue selection can reuse it.
module rr_picker #(
  parameter int N_REQ     = 3,
  parameter int PTR_WIDTH = 2
) (
  input  logic [N_REQ-1:0]     i_request,
  input  logic [PTR_WIDTH-1:0] i_rrPtr,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_anyGrant
);

  int w_bestDist;
  int w_bestIdx;

  // Find the requester closest to the pointer in circular order
  always_comb begin
    o_grant    = '0;
    w_bestDist = N_REQ;
    w_bestIdx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_request[i] && (((i + N_REQ - int'(i_rrPtr)) % N_REQ) < w_bestDist)) begin
        w_bestDist = (i + N_REQ - int'(i_rrPtr)) % N_REQ;
        w_bestIdx  = i;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      o_grant[i] = (w_bestDist < N_REQ) && (i == w_bestIdx);
    end
  end

  assign o_anyGrant = |i_request;

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single ROB result-write port among the ALU, LSB and BRU.
// Each requester owns a one-entry slot; a round-robin picker drains one
// slot per cycle into a registered CDB broadcast.
module cdb_arbiter #(
  parameter int N_REQ      = cdb_arbiter_pkg::N_REQ,
  parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::DATA_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clear_in,
  input  logic [N_REQ-1:0]              req_valid_in,
  input  logic [N_REQ*ROB_WIDTH-1:0]    req_rob_id_in,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_value_in,
  output logic [N_REQ-1:0]              req_ready_out,
  output logic                          cdb_valid_out,
  output logic [ROB_WIDTH-1:0]          cdb_rob_id_out,
  output logic [DATA_WIDTH-1:0]         cdb_value_out,
  output logic [N_REQ-1:0]              cdb_src_out
);

  import cdb_arbiter_pkg::*;

  localparam int PTR_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      r_full;
  logic [ROB_WIDTH-1:0]  r_id  [N_REQ];
  logic [DATA_WIDTH-1:0] r_val [N_REQ];
  logic [PTR_WIDTH-1:0]  r_rrPtr;
  logic                  r_cdbValid;
  logic [ROB_WIDTH-1:0]  r_cdbRobId;
  logic [DATA_WIDTH-1:0] r_cdbValue;
  logic [N_REQ-1:0]      r_cdbSrc;

  logic                  w_active;
  logic [N_REQ-1:0]      w_request;
  logic [N_REQ-1:0]      w_grant;
  logic                  w_anyGrant;
  logic [N_REQ-1:0]      w_ready;
  logic [N_REQ-1:0]      w_push;
  logic [PTR_WIDTH-1:0]  w_grantIdx;
  logic [ROB_WIDTH-1:0]  w_grantId;
  logic [DATA_WIDTH-1:0] w_grantVal;

  // Stall and flush both suppress arbitration and pushes
  assign w_active  = rdy_in && !clear_in;
  assign w_request = w_active ? r_full : '0;

  rr_picker #(
    .N_REQ    (N_REQ),
    .PTR_WIDTH(PTR_WIDTH)
  ) u_picker (
    .i_request (w_request),
    .i_rrPtr   (r_rrPtr),
    .o_grant   (w_grant),
    .o_anyGrant(w_anyGrant)
  );

  // A slot that is draining this cycle can be refilled in the same cycle
  assign w_ready       = w_active ? (~r_full | w_grant) : '0;
  assign w_push        = req_valid_in & w_ready;
  assign req_ready_out = w_ready;

  // Select the contents of the granted slot for the broadcast register
  always_comb begin
    w_grantIdx = '0;
    w_grantId  = '0;
    w_grantVal = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_grantIdx = PTR_WIDTH'(i);
        w_grantId  = r_id[i];
        w_grantVal = r_val[i];
      end
    end
  end

  // Slot storage: push fills, grant empties, flush wipes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_full <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_id[i]  <= '0;
        r_val[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        r_full <= '0;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (w_push[i]) begin
            r_full[i] <= TRUE;
            r_id[i]   <= req_rob_id_in[i*ROB_WIDTH +: ROB_WIDTH];
            r_val[i]  <= req_value_in[i*DATA_WIDTH +: DATA_WIDTH];
          end else if (w_grant[i]) begin
            r_full[i] <= FALSE;
          end
        end
      end
    end
  end

  // Registered CDB broadcast and round-robin pointer advance
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cdbValid <= FALSE;
      r_cdbRobId <= '0;
      r_cdbValue <= '0;
      r_cdbSrc   <= '0;
      r_rrPtr    <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        r_cdbValid <= FALSE;
        r_cdbSrc   <= '0;
        r_rrPtr    <= '0;
      end else if (w_anyGrant) begin
        r_cdbValid <= TRUE;
        r_cdbRobId <= w_grantId;
        r_cdbValue <= w_grantVal;
        r_cdbSrc   <= w_grant;
        r_rrPtr    <= PTR_WIDTH'(nextPtr(int'(w_grantIdx), N_REQ));
      end else begin
        r_cdbValid <= FALSE;
        r_cdbSrc   <= '0;
      end
    end
  end

  assign cdb_valid_out  = r_cdbValid;
  assign cdb_rob_id_out = r_cdbRobId;
  assign cdb_value_out  = r_cdbValue;
  assign cdb_src_out    = r_cdbSrc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios followed by random traffic,
// all compared against a slot/queue-level reference model.
module tb_cdb_arbiter;

  import cdb_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic        rdy;
  logic        clr;
  logic [2:0]  reqValid;
  logic [11:0] reqRobId;
  logic [95:0] reqValue;
  logic [2:0]  reqReady;
  logic        cdbValid;
  logic [3:0]  cdbRobId;
  logic [31:0] cdbValue;
  logic [2:0]  cdbSrc;

  int testCount = 0;
  int failCount = 0;

  // Reference model: what each slot holds, pointer, and the last broadcast
  logic [2:0]  mFull;
  logic [3:0]  mId  [3];
  logic [31:0] mVal [3];
  int          mPtr;
  logic        mValid;
  logic [3:0]  mRobId;
  logic [31:0] mValue;
  logic [2:0]  mSrc;

  cdb_arbiter dut (
    .clk_in        (clock),
    .rst_in        (reset),
    .rdy_in        (rdy),
    .clear_in      (clr),
    .req_valid_in  (reqValid),
    .req_rob_id_in (reqRobId),
    .req_value_in  (reqValue),
    .req_ready_out (reqReady),
    .cdb_valid_out (cdbValid),
    .cdb_rob_id_out(cdbRobId),
    .cdb_value_out (cdbValue),
    .cdb_src_out   (cdbSrc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mFull  = '0;
    mPtr   = 0;
    mValid = 1'b0;
    mRobId = '0;
    mValue = '0;
    mSrc   = '0;
    for (int i = 0; i < 3; i++) begin
      mId[i]  = '0;
      mVal[i] = '0;
    end
  endtask

  // Which slot the scheduler serves now, and which slots accept a push
  task automatic modelDecide(output int g, output logic [2:0] readyVec);
    g = -1;
    readyVec = '0;
    if (rdy && !clr) begin
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && mFull[(mPtr + k) % 3]) g = (mPtr + k) % 3;
      end
      for (int i = 0; i < 3; i++) readyVec[i] = !mFull[i] || (g == i);
    end
  endtask

  task automatic modelEdge(input int g, input logic [2:0] readyVec);
    if (!rdy) return;
    if (clr) begin
      mFull  = '0;
      mValid = 1'b0;
      mSrc   = '0;
      mPtr   = 0;
      return;
    end
    if (g >= 0) begin
      mValid   = 1'b1;
      mRobId   = mId[g];
      mValue   = mVal[g];
      mSrc     = 3'b001 << g;
      mFull[g] = 1'b0;
      mPtr     = (g + 1) % 3;
    end else begin
      mValid = 1'b0;
      mSrc   = '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (reqValid[i] && readyVec[i]) begin
        mFull[i] = 1'b1;
        mId[i]   = reqRobId[i*4 +: 4];
        mVal[i]  = reqValue[i*32 +: 32];
      end
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic [3:0] id,
                        input logic [31:0] val);
    reqValid[i]         = v;
    reqRobId[i*4 +: 4]  = id;
    reqValue[i*32 +: 32] = val;
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic [2:0] v);
    rdy = r;
    clr = c;
    reqValid = v;
  endtask

  // One clock: check readiness before the edge, broadcast after it
  task automatic runCycle(input string tag);
    int g;
    logic [2:0] readyVec;
    #1;
    modelDecide(g, readyVec);
    checkOutput({tag, "/ready"}, reqReady, readyVec);
    @(posedge clock);
    modelEdge(g, readyVec);
    #1;
    checkOutput({tag, "/valid"}, cdbValid, mValid);
    checkOutput({tag, "/robId"}, cdbRobId, mRobId);
    checkOutput({tag, "/value"}, cdbValue, mValue);
    checkOutput({tag, "/src"}, cdbSrc, mSrc);
    checkOutput({tag, "/srcOnehot"},
                $onehot0(cdbSrc) && ((cdbSrc != 3'b000) == cdbValid), 1'b1);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b000);
    reqRobId = '0;
    reqValue = '0;
    modelReset();
    @(negedge clock);
    checkOutput("reset/valid", cdbValid, 1'b0);
    checkOutput("reset/robId", cdbRobId, 4'd0);
    checkOutput("reset/value", cdbValue, 32'd0);
    checkOutput("reset/src", cdbSrc, 3'b000);
    reset = 1'b0;

    // Single ALU push, broadcast one cycle after it lands in the slot
    setReq(REQ_ALU, 1'b1, 4'd5, 32'h1234);
    runCycle("single/push");
    applyStimulus(1'b1, 1'b0, 3'b000);
    runCycle("single/grant");
    checkOutput("single/literalValid", cdbValid, 1'b1);
    checkOutput("single/literalId", cdbRobId, 4'd5);
    checkOutput("single/literalValue", cdbValue, 32'h1234);
    checkOutput("single/literalSrc", cdbSrc, 3'b001);
    runCycle("single/idle");
    checkOutput("single/drained", cdbValid, 1'b0);

    // Simultaneous push from all three requesters
    setReq(REQ_ALU, 1'b1, 4'd1, 32'hA1);
    setReq(REQ_LSB, 1'b1, 4'd2, 32'hB2);
    setReq(REQ_BRU, 1'b1, 4'd3, 32'hC3);
    runCycle("simul/push");
    applyStimulus(1'b1, 1'b0, 3'b000);
    for (int n = 0; n < 4; n++) runCycle("simul/drain");

    // Fairness: ALU streams ids 0..7 while LSB injects id 9 once
    setReq(REQ_LSB, 1'b1, 4'd9, 32'h99);
    for (int n = 0; n < 8; n++) begin
      setReq(REQ_ALU, 1'b1, 4'(n), 32'h100 + 32'(n));
      runCycle("fair/stream");
      reqValid[REQ_LSB] = 1'b0;
    end
    applyStimulus(1'b1, 1'b0, 3'b000);
    for (int n = 0; n < 3; n++) runCycle("fair/drain");

    // Wrap-around: move pointer to 2 via an LSB grant, then fill 0 and 2
    setReq(REQ_LSB, 1'b1, 4'd4, 32'h44);
    runCycle("wrap/lsb");
    applyStimulus(1'b1, 1'b0, 3'b000);
    setReq(REQ_ALU, 1'b1, 4'd6, 32'h66);
    setReq(REQ_BRU, 1'b1, 4'd7, 32'h77);
    runCycle("wrap/fill");
    applyStimulus(1'b1, 1'b0, 3'b000);
    runCycle("wrap/bru");
    checkOutput("wrap/bruFirst", cdbSrc, 3'b100);
    runCycle("wrap/alu");
    checkOutput("wrap/aluSecond", cdbSrc, 3'b001);
    runCycle("wrap/idle");

    // Stall with full slots and a live broadcast
    setReq(REQ_ALU, 1'b1, 4'd10, 32'hD0);
    setReq(REQ_LSB, 1'b1, 4'd11, 32'hD1);
    setReq(REQ_BRU, 1'b1, 4'd12, 32'hD2);
    runCycle("stall/fill");
    runCycle("stall/refill");
    applyStimulus(1'b0, 1'b0, 3'b111);
    for (int n = 0; n < 3; n++) runCycle("stall/frozen");
    applyStimulus(1'b1, 1'b0, 3'b000);
    for (int n = 0; n < 4; n++) runCycle("stall/resume");

    // Flush with every slot full and a push pending
    applyStimulus(1'b1, 1'b0, 3'b111);
    runCycle("flush/fill");
    applyStimulus(1'b1, 1'b1, 3'b111);
    runCycle("flush/clear");
    applyStimulus(1'b1, 1'b0, 3'b000);
    for (int n = 0; n < 3; n++) runCycle("flush/quiet");

    // Asynchronous reset in the middle of a cycle while broadcasting
    applyStimulus(1'b1, 1'b0, 3'b011);
    runCycle("areset/fill");
    applyStimulus(1'b1, 1'b0, 3'b000);
    runCycle("areset/busy");
    #1 reset = 1'b1;
    #1;
    checkOutput("areset/valid", cdbValid, 1'b0);
    checkOutput("areset/robId", cdbRobId, 4'd0);
    checkOutput("areset/value", cdbValue, 32'd0);
    checkOutput("areset/src", cdbSrc, 3'b000);
    #1 reset = 1'b0;
    modelReset();
    @(negedge clock);
    runCycle("areset/after");

    // Random traffic with occasional stalls and flushes
    for (int n = 0; n < 300; n++) begin
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
                    3'($urandom_range(0, 7)));
      reqRobId = 12'($urandom);
      reqValue = {$urandom, $urandom, $urandom};
      runCycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
